// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers the fetched word into IF/ID.
// Optional halt-on-zero-instruction is built when FETCH_HALT_EN is defined.
module fetch_stage #(
  parameter int              PC_W     = 3,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [2:0]         ifid_op,
  output logic [2:0]         ifid_rs,
  output logic [2:0]         ifid_rt,
  output logic [2:0]         ifid_rd,
  output logic [3:0]         ifid_func,
  output logic [7:0]         fetch_count,
  output logic               halted
);

  function automatic logic [PC_W-1:0] inc_pc(input logic [PC_W-1:0] cur);
    return cur + PC_W'(1);
  endfunction

  logic [PC_W-1:0]    pc_p0, pc_p0_nxt;
  logic               vld_p1, vld_p1_nxt;
  logic [INSTR_W-1:0] instr_p1, instr_p1_nxt;
  logic [PC_W-1:0]    pc_p1, pc_p1_nxt;
  logic [7:0]         count_q, count_nxt;
  logic               run_mode;

`ifdef FETCH_HALT_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  state_t state_q, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_nxt;
  end

  assign run_mode = (state_q == RUN);
  assign halted   = (state_q == HALT);
`else
  assign run_mode = 1'b1;
  assign halted   = 1'b0;
`endif

  // Next-state: reset > redirect > halt hold > stall > fetch
  always_comb begin
    pc_p0_nxt    = pc_p0;
    vld_p1_nxt   = vld_p1;
    instr_p1_nxt = instr_p1;
    pc_p1_nxt    = pc_p1;
    count_nxt    = count_q;
`ifdef FETCH_HALT_EN
    state_nxt    = state_q;
`endif
    if (redirect) begin
      pc_p0_nxt    = redirect_pc;
      vld_p1_nxt   = 1'b0;
      instr_p1_nxt = '0;
      pc_p1_nxt    = '0;
`ifdef FETCH_HALT_EN
      state_nxt    = RUN;
`endif
    end else if (!run_mode) begin
      vld_p1_nxt = 1'b0;
    end else if (stall) begin
      pc_p0_nxt = pc_p0;
`ifdef FETCH_HALT_EN
    end else if (instruction == '0) begin
      // Halt word is not captured; PC keeps pointing at it.
      vld_p1_nxt = 1'b0;
      state_nxt  = HALT;
`endif
    end else begin
      pc_p0_nxt    = inc_pc(pc_p0);
      vld_p1_nxt   = 1'b1;
      instr_p1_nxt = instruction;
      pc_p1_nxt    = pc_p0;
      count_nxt    = count_q + 8'd1;
    end
  end

  // Stage p0 (PC) -> p1 (IF/ID register)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      count_q  <= '0;
    end else begin
      pc_p0    <= pc_p0_nxt;
      vld_p1   <= vld_p1_nxt;
      instr_p1 <= instr_p1_nxt;
      pc_p1    <= pc_p1_nxt;
      count_q  <= count_nxt;
    end
  end

  assign pc          = pc_p0;
  assign ifid_valid  = vld_p1;
  assign ifid_instr  = instr_p1;
  assign ifid_pc     = pc_p1;
  assign fetch_count = count_q;
  assign ifid_op     = instr_p1[15:13];
  assign ifid_rs     = instr_p1[12:10];
  assign ifid_rt     = instr_p1[9:7];
  assign ifid_rd     = instr_p1[6:4];
  assign ifid_func   = instr_p1[3:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage with a capture scoreboard.
module tb_fetch_stage;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  pc;
    logic [15:0] instr;
  } item_t;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [2:0]  redirect_pc;
  logic [2:0]  pc;
  logic [15:0] instruction;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [2:0]  ifid_pc, ifid_op, ifid_rs, ifid_rt, ifid_rd;
  logic [3:0]  ifid_func;
  logic [7:0]  fetch_count;
  logic        halted;

  logic [15:0] mem [8];
  item_t       sb [$];
  item_t       last;
  logic [2:0]  m_pc;
  logic        m_vld, m_halted;
  logic [7:0]  m_count;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  assign instruction = mem[pc];

  fetch_stage #(.PC_W(3), .INSTR_W(16), .RESET_PC(3'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .instruction(instruction),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_op(ifid_op), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd),
    .ifid_func(ifid_func), .fetch_count(fetch_count), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic st, input logic rd);
    reset = 1'b1; stall = st; redirect = rd; redirect_pc = 3'd5;
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    m_pc = 3'd0; m_vld = 1'b0; m_count = 8'd0; m_halted = 1'b0; last = '0;
    sb.delete();
    check("rst_pc", pc, 3'd0);
    check("rst_valid", ifid_valid, 1'b0);
    check("rst_instr", ifid_instr, 16'h0000);
    check("rst_ifid_pc", ifid_pc, 3'd0);
    check("rst_count", fetch_count, 8'd0);
    check("rst_halted", halted, 1'b0);
  endtask

  task automatic tick(input logic st, input logic rd, input logic [2:0] rpc);
    logic cap;
    item_t it;
    stall = st; redirect = rd; redirect_pc = rpc; cap = 1'b0;
    if (rd) begin
      m_pc = rpc; m_vld = 1'b0; m_halted = 1'b0; last = '0;
    end else if (m_halted) begin
      m_vld = 1'b0;
    end else if (st) begin
      m_vld = m_vld;
    end else if (HALT_EN && mem[m_pc] == 16'h0000) begin
      m_vld = 1'b0; m_halted = 1'b1;
    end else begin
      it.pc = m_pc; it.instr = mem[m_pc];
      sb.push_back(it);
      cap = 1'b1; m_vld = 1'b1; m_count = m_count + 8'd1; m_pc = m_pc + 3'd1;
    end
    @(posedge clk); #1;
    check("pc", pc, m_pc);
    check("valid", ifid_valid, m_vld);
    check("count", fetch_count, m_count);
    check("halted", halted, m_halted);
    if (cap) begin
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else last = sb.pop_front();
    end
    check("ifid_pc", ifid_pc, last.pc);
    check("ifid_instr", ifid_instr, last.instr);
    check("op", ifid_op, last.instr[15:13]);
    check("rs", ifid_rs, last.instr[12:10]);
    check("rt", ifid_rt, last.instr[9:7]);
    check("rd", ifid_rd, last.instr[6:4]);
    check("func", ifid_func, last.instr[3:0]);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 3'd0;
    mem[0] = 16'h0001; mem[1] = 16'h0001; mem[2] = 16'h0002; mem[3] = 16'h0003;
    for (int i = 4; i < 8; i++) mem[i] = 16'h1234;
    last = '0;
    @(posedge clk); #1;

    // Sequential fetch
    do_reset(1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 3'd0);
    check("seq_count", fetch_count, 8'd4);
    check("seq_ifid_pc", ifid_pc, 3'd3);
    check("seq_func", ifid_func, 4'd3);

    // Wrap-around
    do_reset(1'b0, 1'b0);
    repeat (9) tick(1'b0, 1'b0, 3'd0);
    check("wrap_pc", pc, 3'd1);
    check("wrap_ifid_pc", ifid_pc, 3'd0);
    check("wrap_instr", ifid_instr, 16'h0001);

    // Stall
    do_reset(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 3'd0);
    repeat (3) tick(1'b1, 1'b0, 3'd0);
    check("stall_ifid_pc", ifid_pc, 3'd2);
    check("stall_valid", ifid_valid, 1'b1);
    check("stall_count", fetch_count, 8'd3);
    tick(1'b0, 1'b0, 3'd0);
    check("release_ifid_pc", ifid_pc, 3'd3);

    // Redirect beats stall
    tick(1'b1, 1'b1, 3'd6);
    check("redir_pc", pc, 3'd6);
    check("redir_bubble", ifid_valid, 1'b0);
    tick(1'b0, 1'b0, 3'd0);
    check("redir_target_pc", ifid_pc, 3'd6);
    check("redir_target_valid", ifid_valid, 1'b1);

    // Reset in the middle of a stall
    tick(1'b1, 1'b0, 3'd0);
    do_reset(1'b1, 1'b0);

    // Zero words: halt when built in, ordinary fetch otherwise
    for (int i = 4; i < 8; i++) mem[i] = 16'h0000;
    do_reset(1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 3'd0);
    if (HALT_EN) begin
      check("halt_flag", halted, 1'b1);
      check("halt_pc", pc, 3'd4);
      check("halt_count", fetch_count, 8'd4);
      repeat (10) tick(1'b0, 1'b0, 3'd0);
      tick(1'b1, 1'b0, 3'd0);
      check("halt_hold_pc", pc, 3'd4);
      tick(1'b0, 1'b1, 3'd0);
      check("unhalt_flag", halted, 1'b0);
      tick(1'b0, 1'b0, 3'd0);
      check("unhalt_instr", ifid_instr, 16'h0001);
      repeat (5) tick(1'b0, 1'b0, 3'd0);
      check("rehalt_flag", halted, 1'b1);
    end else begin
      check("zero_fetch_instr", ifid_instr, 16'h0000);
      check("zero_fetch_valid", ifid_valid, 1'b1);
      check("zero_fetch_count", fetch_count, 8'd5);
    end
    do_reset(1'b0, 1'b0);

    // Mixed random traffic
    mem[5] = 16'hA5C3;
    for (int i = 0; i < 60; i++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
    do_reset(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
